weave_tx: RTL and testbench



---
 rtl/weave_pkg.sv | 25 ++
 rtl/weave_baud_tick.sv | 38 +++
 rtl/weave_tx.sv | 143 ++++++++++++++
 tb/tb_weave_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/weave_pkg.sv
// weave_pkg: shared types and constants for the weave_tx serial transmitter.
//   tx_state_t  - transmitter FSM states; PARITY is always declared so the
//                 encoding does not change with the build configuration.
//   WEAVE_DATA_W - word width carried by a frame (fixed at 8).
//   FRAME_BITS   - serial bits per frame: 10, or 11 when WEAVE_TX_PARITY_EN
//                  is defined (even parity bit before the stop bit).
package weave_pkg;

  localparam int WEAVE_DATA_W = 8;

`ifdef WEAVE_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/weave_baud_tick.sv
// weave_baud_tick: bit-period timer for weave_tx.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart the bit period (word accepted)
//   run        - a frame is in flight; the counter only advances while high
//   bit_end    - one-cycle strobe on the last cycle of each bit period
// div_cnt counts 0..CLK_DIV-1 and returns to 0 at the terminal count; with
// CLK_DIV=1 it never leaves 0 and bit_end is high on every running cycle.
module weave_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign bit_end = run && (div_cnt == LAST);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      if (bit_end) div_cnt <= '0;
      else         div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/weave_tx.sv
// weave_tx: UART-style serial transmitter driving one bidirectional IO lane.
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1); each bit
// lasts CLK_DIV clk cycles. Optional parity bit: define WEAVE_TX_PARITY_EN.
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset (line returns high at once)
//   data_in    - word to transmit, sampled only when accepted
//   data_valid - producer has a word
//   data_ready - a word can be accepted this cycle (high only in IDLE)
//   tx         - registered serial line, idle high
//   busy       - frame in flight (START..STOP)
//   oe         - lane output enable, high from the first edge after reset
module weave_tx
  import weave_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy,
  output logic              oe
);

`ifdef WEAVE_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  if (DATA_W != WEAVE_DATA_W) begin : g_bad_data_w
    $error("weave_tx: DATA_W must be %0d", WEAVE_DATA_W);
  end
  if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("weave_tx: CLK_DIV must be in 1..65535");
  end
  if (FRAME_BITS != DATA_W + 2 + PARITY_BITS) begin : g_bad_frame
    $error("weave_tx: FRAME_BITS disagrees with the built frame format");
  end

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              bit_end;
  logic              accept;
`ifdef WEAVE_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign accept = data_valid && data_ready;

  weave_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .run     (busy),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      data_ready <= 1'b1;
      oe         <= 1'b0;
      bit_idx    <= '0;
      // NOTE: the shift register is a handful of flops, not a memory, so it
      // is reset with the rest; no stale bits can leak into a later frame.
      shreg      <= '0;
`ifdef WEAVE_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      oe <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= START;
            shreg      <= data_in;
            bit_idx    <= '0;
            tx         <= 1'b0;
            busy       <= 1'b1;
            data_ready <= 1'b0;
`ifdef WEAVE_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'(DATA_W - 1)) begin
`ifdef WEAVE_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              // Next bit is shreg[1], which becomes the LSB after the shift.
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
`ifdef WEAVE_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state      <= IDLE;
            busy       <= 1'b0;
            data_ready <= 1'b1;
          end
        end
        default: begin
          // Unreachable encodings fall back to a clean idle line.
          state      <= IDLE;
          tx         <= 1'b1;
          busy       <= 1'b0;
          data_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weave_tx.sv
// tb_weave_tx: self-checking bench for weave_tx. Three instances run at
// CLK_DIV = 4, 2 and 1. Expected line values come from a frame model that
// lists the frame's bits (start, data LSB first, optional parity, stop) and
// holds each for CLK_DIV cycles.
module tb_weave_tx;

  localparam int DIVS [3] = '{4, 2, 1};
`ifdef WEAVE_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0][7:0] d_in;
  logic [2:0]      d_valid;
  logic [2:0]      d_ready;
  logic [2:0]      tx_v;
  logic [2:0]      busy_v;
  logic [2:0]      oe_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    weave_tx #(.CLK_DIV(DIVS[g]), .DATA_W(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (d_in[g]),
      .data_valid (d_valid[g]),
      .data_ready (d_ready[g]),
      .tx         (tx_v[g]),
      .busy       (busy_v[g]),
      .oe         (oe_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line value during frame bit b of word w.
  function automatic logic frame_bit(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
`ifdef WEAVE_TX_PARITY_EN
    if (b == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one word on instance i and check every cycle of the frame.
  // keep: leave data_valid high afterwards; pulse_at: frame cycle at which a
  // one-cycle data_valid pulse with 0x11 is driven (-1 for none).
  task automatic send(input int i, input logic [7:0] w, input bit keep, input int pulse_at);
    int cyc = 0;
    check($sformatf("u%0d ready_before", i), d_ready[i], 1);
    check($sformatf("u%0d idle_line", i), tx_v[i], 1);
    d_in[i]    = w;
    d_valid[i] = 1'b1;
    step();
    if (!keep) d_valid[i] = 1'b0;
    d_in[i] = 8'($urandom);
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < DIVS[i]; c++) begin
        if (cyc == pulse_at) begin
          d_valid[i] = 1'b1;
          d_in[i]    = 8'h11;
        end else if (!keep) begin
          d_valid[i] = 1'b0;
        end
        check($sformatf("u%0d w%02h bit%0d tx", i, w, b), tx_v[i], frame_bit(w, b));
        check($sformatf("u%0d w%02h busy", i, w), busy_v[i], 1);
        check($sformatf("u%0d w%02h ready_low", i, w), d_ready[i], 0);
        step();
        cyc++;
      end
    end
    check($sformatf("u%0d w%02h ready_after", i, w), d_ready[i], 1);
    check($sformatf("u%0d w%02h busy_after", i, w), busy_v[i], 0);
    check($sformatf("u%0d w%02h tx_after", i, w), tx_v[i], 1);
  endtask

  // Start word w, assert reset during data bit `bit_n` (cycle offset off),
  // and check the asynchronous return to idle plus a clean restart.
  task automatic rst_mid(input int i, input logic [7:0] w, input int bit_n, input int off);
    d_in[i]    = w;
    d_valid[i] = 1'b1;
    step();
    d_valid[i] = 1'b0;
    for (int k = 0; k < (1 + bit_n) * DIVS[i] + off; k++) step();
    check($sformatf("u%0d rst pre tx", i), tx_v[i], w[bit_n]);
    check($sformatf("u%0d rst pre busy", i), busy_v[i], 1);
    #1 rst_n = 1'b0;
    #1;
    check($sformatf("u%0d rst async tx", i), tx_v[i], 1);
    check($sformatf("u%0d rst async busy", i), busy_v[i], 0);
    check($sformatf("u%0d rst async ready", i), d_ready[i], 1);
    check($sformatf("u%0d rst async oe", i), oe_v[i], 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    check($sformatf("u%0d rst oe_before_edge", i), oe_v[i], 0);
    step();
    check($sformatf("u%0d rst oe_after_edge", i), oe_v[i], 1);
    for (int k = 0; k < 2 * NBITS * DIVS[i]; k++) begin
      check($sformatf("u%0d rst no_residual tx", i), tx_v[i], 1);
      check($sformatf("u%0d rst idle busy", i), busy_v[i], 0);
      check($sformatf("u%0d rst idle ready", i), d_ready[i], 1);
      step();
    end
  endtask

  initial begin
    int  i;
    bit  keep;
    bit  prev_keep;
    int  pulse;
    int  idle;

    rst_n   = 1'b0;
    d_valid = '0;
    d_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d reset tx", k), tx_v[k], 1);
      check($sformatf("u%0d reset busy", k), busy_v[k], 0);
      check($sformatf("u%0d reset ready", k), d_ready[k], 1);
      check($sformatf("u%0d reset oe", k), oe_v[k], 0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) check($sformatf("u%0d oe_up", k), oe_v[k], 1);

    // Directed cases.
    send(0, 8'hA5, 1'b0, -1);
    send(1, 8'h3C, 1'b1, -1);        // valid held: next word in first IDLE cycle
    send(1, 8'hFF, 1'b0, -1);
    send(0, 8'h00, 1'b0, 13);        // mid-frame pulse is ignored
    step();
    rst_mid(0, 8'h0F, 3, 2);
    rst_mid(1, 8'hE5, 4, 1);
    send(2, 8'h80, 1'b0, -1);
    send(1, 8'h07, 1'b0, -1);
    step();

    // Randomized frames, instances, back-to-back holds and busy pulses.
    i         = 0;
    prev_keep = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!prev_keep) i = int'($urandom_range(0, 2));
      keep  = (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      pulse = (!keep && $urandom_range(0, 1) == 1)
              ? int'($urandom_range(0, NBITS * DIVS[i] - 2)) : -1;
      send(i, 8'($urandom), keep, pulse);
      prev_keep = keep;
      if (!keep) begin
        idle = int'($urandom_range(1, 3));
        for (int k = 0; k < idle; k++) begin
          step();
          check($sformatf("u%0d gap tx", i), tx_v[i], 1);
          check($sformatf("u%0d gap busy", i), busy_v[i], 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
